upc_checkout_ctrl: RTL and testbench

UPC_CHECKOUT_CTRL -- requirements
Module: upc_checkout_ctrl

---
 rtl/upc_checkout_ctrl.sv | 120 ++++++++++++
 tb/tb_upc_checkout_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/upc_checkout_ctrl.sv
// Checkout controller: classifies scanned items by their {U,P,C} code and mark bit.
// It counts accepted and discounted items and freezes on a stolen item or on a full basket.
module upc_checkout_ctrl #(
  parameter int CNT_W     = 4,
  parameter int MAX_ITEMS = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       upc,
  input  logic             mark,
  input  logic             scan,
  input  logic             clear,
  output logic [CNT_W-1:0] item_cnt,
  output logic [CNT_W-1:0] disc_cnt,
  output logic             exp_flag,
  output logic             alarm,
  output logic             full,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    EVAL  = 2'd1,
    ALARM = 2'd2,
    FULL  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITEMS);
  localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

  state_t           state, state_next;
  logic             scan_d, scan_pulse;
  logic [2:0]       cap_upc;
  logic             cap_mark, capture;
  logic [CNT_W-1:0] item_next, disc_next;
  logic             exp_next, alarm_next;
  logic             u, p, c, discount, expensive, stolen;

  assign scan_pulse = scan & ~scan_d;

  assign u         = cap_upc[2];
  assign p         = cap_upc[1];
  assign c         = cap_upc[0];
  assign discount  = (u & c) | p;
  assign expensive = ((~p & ~c) | (~p & u)) & ~cap_mark;
  assign stolen    = (u & ~p & ~c) | (~p & ~c & ~cap_mark);

  assign busy = (state != IDLE);
  assign full = (state == FULL);

  // Edge detector tracks scan even through reset so a held level never re-triggers.
  always_ff @(posedge clk) begin
    scan_d <= scan;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      item_cnt <= '0;
      disc_cnt <= '0;
      exp_flag <= 1'b0;
      alarm    <= 1'b0;
      cap_upc  <= '0;
      cap_mark <= 1'b0;
    end else begin
      state    <= state_next;
      item_cnt <= item_next;
      disc_cnt <= disc_next;
      exp_flag <= exp_next;
      alarm    <= alarm_next;
      if (capture) begin
        cap_upc  <= upc;
        cap_mark <= mark;
      end
    end
  end

  always_comb begin
    state_next = state;
    item_next  = item_cnt;
    disc_next  = disc_cnt;
    exp_next   = exp_flag;
    alarm_next = alarm;
    capture    = 1'b0;
    if (clear) begin
      state_next = IDLE;
      item_next  = '0;
      disc_next  = '0;
      exp_next   = 1'b0;
      alarm_next = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (scan_pulse) begin
            state_next = EVAL;
            capture    = 1'b1;
          end
        end
        EVAL: begin
          if (stolen) begin
            state_next = ALARM;
            alarm_next = 1'b1;
          end else begin
            // Guard keeps counters from wrapping even if MAX_ITEMS is misconfigured.
            if (item_cnt != MAX_CNT) begin
              item_next = item_cnt + ONE;
              if (discount) disc_next = disc_cnt + ONE;
            end
            exp_next   = expensive;
            state_next = (item_next == MAX_CNT) ? FULL : IDLE;
          end
        end
        ALARM:   state_next = ALARM;
        FULL:    state_next = FULL;
        default: state_next = IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_upc_checkout_ctrl.sv
// Self-checking bench for upc_checkout_ctrl: table-driven classification, directed
// corner sequences, then randomized stimulus against a behavioural checkout model.
module tb_upc_checkout_ctrl;

  localparam int MAX = 9;

  logic       clk = 1'b0;
  logic       reset, mark, scan, clear;
  logic [2:0] upc;
  logic [3:0] item_cnt, disc_cnt;
  logic       exp_flag, alarm, full, busy;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: an item is "in flight" for one cycle after a scan edge.
  logic       m_prev_scan = 1'b0;
  logic       m_pending = 1'b0;
  logic [2:0] m_pupc = '0;
  logic       m_pmark = 1'b0;
  int         m_items = 0, m_disc = 0;
  logic       m_exp = 1'b0, m_alarm = 1'b0;

  typedef struct {
    logic [2:0] upc;
    logic       mark;
    logic [3:0] item;
    logic [3:0] disc;
    logic       exp_flag;
    logic       alarm;
  } vec_t;

  vec_t vecs[16];

  upc_checkout_ctrl #(.CNT_W(4), .MAX_ITEMS(MAX)) dut (
    .clk(clk), .reset(reset), .upc(upc), .mark(mark), .scan(scan), .clear(clear),
    .item_cnt(item_cnt), .disc_cnt(disc_cnt), .exp_flag(exp_flag),
    .alarm(alarm), .full(full), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic modelStep();
    logic pulse, u, p, c, st;
    pulse = scan & ~m_prev_scan;
    if (reset) begin
      m_pending = 1'b0; m_items = 0; m_disc = 0; m_exp = 1'b0; m_alarm = 1'b0;
      m_pupc = '0; m_pmark = 1'b0;
    end else if (clear) begin
      m_pending = 1'b0; m_items = 0; m_disc = 0; m_exp = 1'b0; m_alarm = 1'b0;
    end else if (m_pending) begin
      m_pending = 1'b0;
      u = m_pupc[2]; p = m_pupc[1]; c = m_pupc[0];
      st = (u && !p && !c) || (!p && !c && !m_pmark);
      if (st) m_alarm = 1'b1;
      else begin
        m_items = m_items + 1;
        if ((u && c) || p) m_disc = m_disc + 1;
        m_exp = ((!p && !c) || (!p && u)) && !m_pmark;
      end
    end else if (!m_alarm && m_items != MAX && pulse) begin
      m_pending = 1'b1; m_pupc = upc; m_pmark = mark;
    end
    m_prev_scan = scan;
  endtask

  task automatic cycle(input int n = 1);
    for (int i = 0; i < n; i++) begin
      modelStep();
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [2:0] u, input logic m, input logic s,
                               input logic cl, input logic r);
    upc = u; mark = m; scan = s; clear = cl; reset = r;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] e_item,
                             input logic [3:0] e_disc, input logic e_exp,
                             input logic e_alarm, input logic e_full, input logic e_busy);
    checks++;
    if (item_cnt !== e_item || disc_cnt !== e_disc || exp_flag !== e_exp ||
        alarm !== e_alarm || full !== e_full || busy !== e_busy) begin
      failures++;
      $display("[TB] FAIL %s: got item=%0d disc=%0d exp=%b alarm=%b full=%b busy=%b, want item=%0d disc=%0d exp=%b alarm=%b full=%b busy=%b",
               name, item_cnt, disc_cnt, exp_flag, alarm, full, busy,
               e_item, e_disc, e_exp, e_alarm, e_full, e_busy);
    end
  endtask

  task automatic checkModel(input string name);
    checkOutput(name, 4'(m_items), 4'(m_disc), m_exp, m_alarm, (m_items == MAX),
                m_pending || m_alarm || (m_items == MAX));
  endtask

  // One item: scan edge, then drop scan and scramble upc/mark after capture.
  task automatic scanItem(input logic [2:0] u, input logic m);
    applyStimulus(u, m, 1'b1, 1'b0, 1'b0);
    cycle();
    applyStimulus(~u, ~m, 1'b0, 1'b0, 1'b0);
    cycle(2);
  endtask

  initial begin
    vecs[0]  = '{3'b000, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1};
    vecs[1]  = '{3'b000, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0};
    vecs[2]  = '{3'b001, 1'b0, 4'd1, 4'd0, 1'b0, 1'b0};
    vecs[3]  = '{3'b001, 1'b1, 4'd1, 4'd0, 1'b0, 1'b0};
    vecs[4]  = '{3'b010, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0};
    vecs[5]  = '{3'b010, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0};
    vecs[6]  = '{3'b011, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0};
    vecs[7]  = '{3'b011, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0};
    vecs[8]  = '{3'b100, 1'b0, 4'd0, 4'd0, 1'b0, 1'b1};
    vecs[9]  = '{3'b100, 1'b1, 4'd0, 4'd0, 1'b0, 1'b1};
    vecs[10] = '{3'b101, 1'b0, 4'd1, 4'd1, 1'b1, 1'b0};
    vecs[11] = '{3'b101, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0};
    vecs[12] = '{3'b110, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0};
    vecs[13] = '{3'b110, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0};
    vecs[14] = '{3'b111, 1'b0, 4'd1, 4'd1, 1'b0, 1'b0};
    vecs[15] = '{3'b111, 1'b1, 4'd1, 4'd1, 1'b0, 1'b0};

    applyStimulus(3'b111, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle(3);
    checkOutput("reset_state", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Normal scan with an EVAL-cycle peek.
    applyStimulus(3'b101, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle();
    checkOutput("eval_busy", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle();
    checkOutput("normal_scan", 4'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);

    for (int i = 0; i < 16; i++) begin
      applyStimulus(3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
      cycle();
      scanItem(vecs[i].upc, vecs[i].mark);
      checkOutput($sformatf("class_%03b_%b", vecs[i].upc, vecs[i].mark), vecs[i].item,
                  vecs[i].disc, vecs[i].exp_flag, vecs[i].alarm, 1'b0, vecs[i].alarm);
      if (vecs[i].alarm) begin
        scanItem(3'b010, 1'b1);
        checkOutput($sformatf("alarm_hold_%0d", i), 4'd0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
        applyStimulus(3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        checkOutput($sformatf("alarm_clear_%0d", i), 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
      end
    end

    // Fill to the limit, then verify the basket is frozen.
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    for (int i = 0; i < MAX; i++) scanItem(3'b010, 1'b1);
    checkOutput("fill_limit", 4'd9, 4'd9, 1'b0, 1'b0, 1'b1, 1'b1);
    scanItem(3'b010, 1'b1);
    checkOutput("fill_extra", 4'd9, 4'd9, 1'b0, 1'b0, 1'b1, 1'b1);
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    checkOutput("fill_clear", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Held scan yields a single item.
    applyStimulus(3'b111, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(20);
    checkOutput("held_scan", 4'd1, 4'd1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Clear coincident with a scan edge wins; the held level must not re-trigger.
    applyStimulus(3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle();
    applyStimulus(3'b101, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle();
    checkOutput("clear_vs_scan", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b101, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(3);
    checkOutput("clear_vs_scan_after", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset during EVAL discards the item and earlier counts.
    applyStimulus(3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle();
    scanItem(3'b101, 1'b0);
    checkOutput("pre_reset_item", 4'd1, 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b010, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle();
    applyStimulus(3'b010, 1'b1, 1'b0, 1'b1, 1'b1);
    cycle();
    checkOutput("reset_in_eval", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(3'b010, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(2);
    checkOutput("reset_in_eval_after", 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      logic [2:0] ru;
      ru = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'($urandom_range(0, 7));
      applyStimulus(ru, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    ($urandom_range(0, 99) < 2), ($urandom_range(0, 199) < 1));
      cycle();
      checkModel($sformatf("random_%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
